// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ==================================================================
// Package : stopwatch_pkg
// Brief   : Shared BCD digit type, 7-segment patterns and width helper.
// Revision: 1.0
// ==================================================================
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] c_SEG_0     = 7'h3F;
  localparam logic [6:0] c_SEG_1     = 7'h06;
  localparam logic [6:0] c_SEG_2     = 7'h5B;
  localparam logic [6:0] c_SEG_3     = 7'h4F;
  localparam logic [6:0] c_SEG_4     = 7'h66;
  localparam logic [6:0] c_SEG_5     = 7'h6D;
  localparam logic [6:0] c_SEG_6     = 7'h7D;
  localparam logic [6:0] c_SEG_7     = 7'h07;
  localparam logic [6:0] c_SEG_8     = 7'h7F;
  localparam logic [6:0] c_SEG_9     = 7'h6F;
  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int scan_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] seg_decode(input bcd_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = c_SEG_0;
      4'd1:    seg = c_SEG_1;
      4'd2:    seg = c_SEG_2;
      4'd3:    seg = c_SEG_3;
      4'd4:    seg = c_SEG_4;
      4'd5:    seg = c_SEG_5;
      4'd6:    seg = c_SEG_6;
      4'd7:    seg = c_SEG_7;
      4'd8:    seg = c_SEG_8;
      4'd9:    seg = c_SEG_9;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ==================================================================
// Module  : bcd_digit
// Brief   : One decimal digit of the cascaded up/down BCD counter.
// Revision: 1.0
// ==================================================================
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  input  logic i_down,
  input  logic i_clear,
  output bcd_t o_value,
  output logic o_carry
);

  bcd_t r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_tick) begin
      if (i_down)
        r_value <= (r_value == 4'd0) ? 4'd9 : r_value - 4'd1;
      else
        r_value <= (r_value >= 4'd9) ? 4'd0 : r_value + 4'd1;
    end
  end

  // Carry on 9->0 going up, borrow on 0->9 going down.
  assign o_carry = i_tick & (i_down ? (r_value == 4'd0) : (r_value >= 4'd9));
  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ==================================================================
// Module  : bcd_stopwatch
// Brief   : Prescaled up/down BCD stopwatch with multiplexed 7-seg scan;
//           define BCD_STOPWATCH_BLANK_EN to blank leading zero digits.
// Revision: 1.0
// ==================================================================
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 1000,
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                down,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digit_sel,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                running
);

  localparam int c_PW  = scan_idx_width(CLK_HZ);
  localparam int c_SCW = scan_idx_width(SCAN_CYCLES);
  localparam int c_IW  = scan_idx_width(DIGITS);

  logic              r_ss_cur;
  logic              r_ss_prev;
  logic              r_ss_armed;
  logic              r_running;
  logic [c_PW-1:0]   r_presc;
  logic [c_SCW-1:0]  r_scan_cnt;
  logic [c_IW-1:0]   r_scan_idx;
  logic [DIGITS-1:0] r_digit_sel;
  logic [6:0]        r_segments;

  logic              w_ss_rise;
  logic              w_tick;
  logic [DIGITS:0]   w_carry;
  logic              w_unused_wrap;
  logic              w_scan_adv;
  logic [c_IW-1:0]   w_idx_nxt;
  bcd_t              w_digit_nxt;
  logic              w_blank_nxt;

  assign w_ss_rise = r_ss_cur & ~r_ss_prev;
  assign w_tick    = r_running && (r_presc == c_PW'(CLK_HZ - 1));

  // The first edge after reset loads both stages, so a level already high
  // across reset release is not seen as a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ss_cur   <= 1'b0;
      r_ss_prev  <= 1'b0;
      r_ss_armed <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_ss_cur   <= start_stop;
      r_ss_prev  <= r_ss_armed ? r_ss_cur : start_stop;
      r_ss_armed <= 1'b1;
      r_running  <= r_running ^ w_ss_rise;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_presc <= '0;
    else if (clear || w_tick)
      r_presc <= '0;
    else if (r_running)
      r_presc <= r_presc + c_PW'(1);
  end

  assign w_carry[0]    = w_tick;
  assign w_unused_wrap = w_carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clock   (clock),
      .reset   (reset),
      .i_tick  (w_carry[i]),
      .i_down  (down),
      .i_clear (clear),
      .o_value (count_bcd[4*i +: 4]),
      .o_carry (w_carry[i+1])
    );
  end

  // Outputs are computed from the next scan index so digit_sel and
  // segments always change together.
  always_comb begin
    w_scan_adv  = (r_scan_cnt == c_SCW'(SCAN_CYCLES - 1));
    w_idx_nxt   = r_scan_idx;
    if (w_scan_adv)
      w_idx_nxt = (r_scan_idx == c_IW'(DIGITS - 1)) ? '0 : r_scan_idx + c_IW'(1);
    w_digit_nxt = '0;
    w_blank_nxt = 1'b0;
`ifdef BCD_STOPWATCH_BLANK_EN
    begin : b_lead
      logic v_lead;
      v_lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        v_lead = v_lead && (count_bcd[4*i +: 4] == 4'd0) && (i != 0);
        if (w_idx_nxt == c_IW'(i)) begin
          w_digit_nxt = count_bcd[4*i +: 4];
          w_blank_nxt = v_lead;
        end
      end
    end
`else
    for (int i = 0; i < DIGITS; i++)
      if (w_idx_nxt == c_IW'(i))
        w_digit_nxt = count_bcd[4*i +: 4];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_digit_sel <= DIGITS'(1);
      r_segments  <= c_SEG_0;
    end else begin
      r_scan_cnt  <= w_scan_adv ? '0 : r_scan_cnt + c_SCW'(1);
      r_scan_idx  <= w_idx_nxt;
      r_digit_sel <= DIGITS'(1) << w_idx_nxt;
      r_segments  <= w_blank_nxt ? c_SEG_BLANK : seg_decode(w_digit_nxt);
    end
  end

  assign running   = r_running;
  assign digit_sel = r_digit_sel;
  assign segments  = r_segments;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// Bench for bcd_stopwatch: a 2-digit counting instance checked against an
// integer model, and a 4-digit instance for scan and blanking.
module tb_bcd_stopwatch;

  localparam int HZ  = 4;
  localparam int MOD = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ss_a = 1'b0, clr_a = 1'b0, down_a = 1'b0;
  logic ss_b = 1'b0, clr_b = 1'b0, down_b = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic [1:0]  sel_a;
  logic [3:0]  sel_b;
  logic [7:0]  cnt_a;
  logic [15:0] cnt_b;
  logic        run_a, run_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.CLK_HZ(HZ), .DIGITS(2), .SCAN_CYCLES(4)) dut_a (
    .clock(clk), .reset(reset), .start_stop(ss_a), .clear(clr_a), .down(down_a),
    .segments(seg_a), .digit_sel(sel_a), .count_bcd(cnt_a), .running(run_a)
  );

  bcd_stopwatch #(.CLK_HZ(HZ), .DIGITS(4), .SCAN_CYCLES(2)) dut_b (
    .clock(clk), .reset(reset), .start_stop(ss_b), .clear(clr_b), .down(down_b),
    .segments(seg_b), .digit_sel(sel_b), .count_bcd(cnt_b), .running(run_b)
  );

  // Reference for dut_a: count as a plain integer modulo 100.
  int m_cnt, m_presc;
  bit m_run, m_pend, m_fresh, m_last;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_presc <= 0; m_run <= 0; m_pend <= 0; m_fresh <= 1; m_last <= 0;
    end else begin
      if (clr_a) begin
        m_cnt <= 0; m_presc <= 0;
      end else if (m_run) begin
        if (m_presc == HZ - 1) begin
          m_presc <= 0;
          m_cnt <= down_a ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
        end else begin
          m_presc <= m_presc + 1;
        end
      end
      if (m_pend) m_run <= !m_run;
      m_pend  <= !m_fresh && ss_a && !m_last;
      m_last  <= ss_a;
      m_fresh <= 0;
    end
  end

  function automatic logic [7:0] tobcd(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic wait_changes(input int n, input int budget, output int got);
    logic [7:0] p;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      p = cnt_a;
      @(negedge clk);
      if (cnt_a !== p) got++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL reset_count: got %h want 00", cnt_a); end
    total++; if (run_a !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", run_a); end
    total++; if (sel_a !== 2'b01) begin bad++; $display("FAIL reset_sel_a: got %b want 01", sel_a); end
    total++; if (seg_a !== 7'h3F) begin bad++; $display("FAIL reset_seg_a: got %h want 3f", seg_a); end
    total++; if (sel_b !== 4'b0001) begin bad++; $display("FAIL reset_sel_b: got %b want 0001", sel_b); end
    total++; if (cnt_b !== 16'h0) begin bad++; $display("FAIL reset_count_b: got %h want 0000", cnt_b); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_count_up();
    logic [7:0] p;
    int last, changes;
    last = -1; changes = 0;
    down_a = 1'b0;
    ss_a = 1'b1; @(negedge clk); ss_a = 1'b0;
    for (int c = 0; c < 400 && changes < 40; c++) begin
      p = cnt_a;
      @(negedge clk);
      if (cnt_a !== p) begin
        if (last >= 0) begin
          total++;
          if (c - last != HZ) begin bad++; $display("FAIL tick_period: got %0d want %0d", c - last, HZ); end
        end
        last = c; changes++;
      end
    end
    total++; if (changes != 40) begin bad++; $display("FAIL count_ticks: got %0d want 40", changes); end
    total++; if (cnt_a !== 8'h40) begin bad++; $display("FAIL count_40: got %h want 40", cnt_a); end
    total++; if (cnt_a !== tobcd(m_cnt)) begin bad++; $display("FAIL count_model: got %h want %h", cnt_a, tobcd(m_cnt)); end
  endtask

  task automatic test_wrap();
    int got;
    down_a = 1'b0;
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL wrap_clear: got %h want 00", cnt_a); end
    wait_changes(99, 99 * HZ + 20, got);
    total++; if (got != 99 || cnt_a !== 8'h99) begin bad++; $display("FAIL wrap_99: got %h (%0d ticks) want 99", cnt_a, got); end
    wait_changes(1, HZ + 4, got);
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL wrap_up: got %h want 00", cnt_a); end
    down_a = 1'b1;
    wait_changes(1, HZ + 4, got);
    total++; if (cnt_a !== 8'h99) begin bad++; $display("FAIL wrap_down: got %h want 99", cnt_a); end
    down_a = 1'b0;
  endtask

  task automatic test_clear_tick();
    logic [7:0] p;
    int c;
    bit found;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = m_run && (m_presc == HZ - 1);
    end
    total++; if (!found) begin bad++; $display("FAIL clear_tick_setup: got no tick-ready cycle want one"); end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL clear_tick_count: got %h want 00", cnt_a); end
    total++; if (run_a !== 1'b1) begin bad++; $display("FAIL clear_tick_running: got %b want 1", run_a); end
    p = cnt_a; c = 0;
    while (c < 3 * HZ && cnt_a === p) begin @(negedge clk); c++; end
    total++; if (c != HZ) begin bad++; $display("FAIL clear_tick_presc: got first tick after %0d want %0d", c, HZ); end
    total++; if (cnt_a !== 8'h01) begin bad++; $display("FAIL clear_tick_next: got %h want 01", cnt_a); end
  endtask

  task automatic test_stop_start();
    logic [7:0] held;
    bit found;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = m_run && (m_presc == 0);
    end
    ss_a = 1'b1; @(negedge clk); ss_a = 1'b0; @(negedge clk);
    total++; if (run_a !== 1'b0) begin bad++; $display("FAIL stop_running: got %b want 0", run_a); end
    held = cnt_a;
    repeat (50) @(negedge clk);
    total++; if (cnt_a !== held) begin bad++; $display("FAIL stop_frozen: got %h want %h", cnt_a, held); end
    ss_a = 1'b1; @(negedge clk); ss_a = 1'b0; @(negedge clk);
    total++; if (run_a !== 1'b1) begin bad++; $display("FAIL restart_running: got %b want 1", run_a); end
    @(negedge clk);
    total++; if (cnt_a !== held) begin bad++; $display("FAIL restart_early: got %h want %h", cnt_a, held); end
    @(negedge clk);
    total++; if (cnt_a !== tobcd((held[7:4] * 10 + held[3:0] + 1) % MOD)) begin
      bad++; $display("FAIL restart_tick: got %h want %h", cnt_a, tobcd((held[7:4] * 10 + held[3:0] + 1) % MOD));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++; if (cnt_a !== tobcd(m_cnt)) begin bad++; $display("FAIL rand_count: cycle %0d got %h want %h", c, cnt_a, tobcd(m_cnt)); end
      total++; if (run_a !== m_run) begin bad++; $display("FAIL rand_running: cycle %0d got %b want %b", c, run_a, m_run); end
      if ($urandom_range(0, 24) == 0) down_a = ~down_a;
      clr_a = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) ss_a = ~ss_a;
    end
    clr_a = 1'b0; down_a = 1'b0; ss_a = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic [3:0] p;
    int c;
    bit found;
`ifdef BCD_STOPWATCH_BLANK_EN
    exp_seg = '{7'h5B, 7'h06, 7'h00, 7'h00};
`else
    exp_seg = '{7'h5B, 7'h06, 7'h3F, 7'h3F};
`endif
    ss_b = 1'b1; @(negedge clk); ss_b = 1'b0;
    c = 0;
    while (c < 100 && cnt_b !== 16'h0012) begin @(negedge clk); c++; end
    ss_b = 1'b1; @(negedge clk); ss_b = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (cnt_b !== 16'h0012 || run_b !== 1'b0) begin
      bad++; $display("FAIL scan_setup: got count %h run %b want 0012 0", cnt_b, run_b);
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      p = sel_b; @(negedge clk);
      found = (p === 4'b1000) && (sel_b === 4'b0001);
    end
    total++; if (!found) begin bad++; $display("FAIL scan_align: got sel %b want 1000->0001", sel_b); end
    for (int i = 0; i < 16; i++) begin
      total++; if (sel_b !== 4'(1 << ((i / 2) % 4))) begin
        bad++; $display("FAIL scan_sel: step %0d got %b want %b", i, sel_b, 4'(1 << ((i / 2) % 4)));
      end
      total++; if (seg_b !== exp_seg[(i / 2) % 4]) begin
        bad++; $display("FAIL scan_seg: step %0d got %h want %h", i, seg_b, exp_seg[(i / 2) % 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    clr_a = 1'b0; down_a = 1'b0; ss_a = 1'b0;
    repeat (3) @(negedge clk);
    if (run_a) begin
      ss_a = 1'b1; @(negedge clk); ss_a = 1'b0; repeat (3) @(negedge clk);
    end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    ss_a = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (run_a !== 1'b1 || cnt_a !== tobcd(m_cnt)) begin
      bad++; $display("FAIL areset_pre: got run %b count %h want 1 %h", run_a, cnt_a, tobcd(m_cnt));
    end
    @(posedge clk); #2 reset = 1'b1; #1;
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL areset_count: got %h want 00", cnt_a); end
    total++; if (run_a !== 1'b0) begin bad++; $display("FAIL areset_running: got %b want 0", run_a); end
    total++; if (sel_a !== 2'b01 || seg_a !== 7'h3F) begin
      bad++; $display("FAIL areset_display: got sel %b seg %h want 01 3f", sel_a, seg_a);
    end
    total++; if (cnt_b !== 16'h0 || sel_b !== 4'b0001) begin
      bad++; $display("FAIL areset_b: got count %h sel %b want 0000 0001", cnt_b, sel_b);
    end
    @(negedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (run_a !== 1'b0) begin bad++; $display("FAIL areset_release: got running %b want 0", run_a); end
    total++; if (cnt_a !== 8'h00) begin bad++; $display("FAIL areset_hold: got %h want 00", cnt_a); end
    ss_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_clear_tick();
    test_stop_start();
    test_random();
    test_scan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000, meaning clock cycles per count tick (>=2).
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of BCD digits (1..8).
REQ-003 SHALL have parameter SCAN_CYCLES, default 4, meaning clock cycles each digit is driven during display multiplexing (>=1).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start_stop, input, 1, level input; each rising edge toggles run state.
REQ-007 SHALL have port clear, input, 1, synchronous clear of count and prescaler while high.
REQ-008 SHALL have port down, input, 1, count direction: 0 up, 1 down.
REQ-009 SHALL have port segments, output, 7, active-high segments of the currently scanned digit (bit0=a .. bit6=g).
REQ-010 SHALL have port digit_sel, output, DIGITS, one-hot select of the scanned digit.
REQ-011 SHALL have port count_bcd, output, 4*DIGITS, full BCD count, digit 0 in bits [3:0].
REQ-012 SHALL have port running, output, 1, current run state.

Function
REQ-013 SHALL register start_stop and detect a rising edge as prev=0, cur=1; each edge inverts running one cycle later.
REQ-014 SHALL advance a prescaler 0..CLK_HZ-1 only while running; tick asserted for one cycle when prescaler = CLK_HZ-1, then prescaler returns to 0 (exact period CLK_HZ cycles).
REQ-015 SHALL, on tick with down=0, increment count as cascaded decimal: digit 9 -> 0 with carry to next; all-9s -> all-0s (wrap).
REQ-016 SHALL, on tick with down=1, decrement: digit 0 -> 9 with borrow; all-0s -> all-9s (wrap).
REQ-017 SHALL never hold a digit value above 9.
REQ-018 SHALL give clear priority over tick: count and prescaler go to 0 the cycle after clear sampled high; running unchanged.
REQ-019 SHALL, when stopped, freeze prescaler and count; restart resumes from frozen prescaler value.
REQ-020 SHALL sample down only at tick; a change mid-period affects the next tick only.
REQ-021 SHALL scan digits 0,1,..DIGITS-1,0.. advancing every SCAN_CYCLES cycles regardless of running; segments and digit_sel registered and consistent in the same cycle.
REQ-022 SHALL decode digits 0-9 to standard 7-segment patterns (0 -> 7'h3F, 1 -> 7'h06, 8 -> 7'h7F).

Reset
REQ-023 SHALL on reset: count_bcd=0, prescaler=0, running=0, edge register=0, scan index=0, digit_sel=1 (digit 0), segments=7'h3F.
REQ-024 SHALL apply reset immediately and asynchronously, including mid-period and mid-scan; release resumes with no spurious toggle if start_stop is held high across release.

Configuration
REQ-025 SHALL support macro BCD_STOPWATCH_BLANK_EN: when defined, leading zero digits (most significant down to first nonzero, never digit 0) drive segments=7'h00 while selected; when undefined all digits display normally.
REQ-026 SHALL leave count_bcd, running and digit_sel identical with and without the macro.

Structure
REQ-027 SHALL place the seven-segment pattern constants, a BCD digit typedef (4 bits) and the scan-index width function in shared package stopwatch_pkg.
REQ-028 SHALL implement one digit as sub-module bcd_digit (inputs tick-in, down, clear; outputs value, carry/borrow-out), instantiated DIGITS times in a generate chain.

Verification
REQ-029 SHALL verify count up: CLK_HZ=4, DIGITS=2, start pulse, 40 ticks -> count_bcd=8'h40, tick period exactly 4 cycles.
REQ-030 SHALL verify wrap: preload via 99 ticks up then 1 more -> 8'h00; from 8'h00 down 1 tick -> 8'h99.
REQ-031 SHALL verify clear and tick in same cycle -> count 0, prescaler 0, running stays 1.
REQ-032 SHALL verify stop/start: stop at prescaler=2, wait 50 cycles, count unchanged; restart -> next tick after 1 more cycle.
REQ-033 SHALL verify scan: SCAN_CYCLES=2, DIGITS=4 -> digit_sel 0001,0010,0100,1000 each 2 cycles; count 0012 with BLANK_EN shows segments 00,00,06(1),5B(2) on digits 3,2,1,0.
REQ-034 SHALL verify async reset asserted mid-count with start_stop held high -> outputs at REQ-023 values without a clock edge; running stays 0 after release.
